nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 177 +++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two W-bit operands (W = 4*NIBBLES) one nibble at a time through an
//   external 4-bit adder. Nibbles are processed LSB-first. The carry returned
//   by the adder for one nibble is fed back as the carry into the next nibble.
//
//   Optional feature: define NIBBLE_SERIAL_SUB_EN to add the 'sub' input.
//   When sub is captured high, the block computes A - B, formed as
//   A + ~B + 1. In that mode c_out = 1 means no borrow occurred.
//
// Ports
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous active-high reset
//   start  in   1  request an addition (accepted only in IDLE)
//   a, b   in   W  operands, captured when start is accepted
//   c_in   in   1  carry into nibble 0, captured when start is accepted
//   sub    in   1  (NIBBLE_SERIAL_SUB_EN only) subtract, captured with the operands
//   x, y   out  4  current A / B nibble sent to the external adder
//   ci     out  1  carry sent to the external adder
//   s, co  in   4/1 sum and carry returned by the external adder
//   sum    out  W  result, valid in DONE and in the IDLE that follows
//   c_out  out  1  final carry, valid in DONE and in the IDLE that follows
//   busy   out  1  high while a nibble is being processed (ADD)
//   done   out  1  one-cycle pulse when the result is valid (DONE)
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic                   sub,
`endif
  output logic [3:0]             x,
  output logic [3:0]             y,
  output logic                   ci,
  input  logic [3:0]             s,
  input  logic                   co,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out,
  output logic                   busy,
  output logic                   done
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     sum_r;
  logic             c_out_r;
  logic             busy_r;
  logic             done_r;
  logic             sub_s;
  logic             sub_r;
  logic [3:0]       b_nib_s;

`ifdef NIBBLE_SERIAL_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ADD;
        end else begin
          state_s = IDLE;
        end
      end
      ADD: begin
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = ADD;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, nibble sequencing, result accumulation and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      sub_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            idx_r   <= '0;
            sub_r   <= sub_s;
            // Subtraction needs the +1 of the two's complement, so c_in is ignored
            carry_r <= sub_s ? 1'b1 : c_in;
          end
        end
        ADD: begin
          sum_r[{idx_r, 2'b00} +: 4] <= s;
          carry_r                    <= co;
          if (idx_r == LAST_IDX) begin
            idx_r   <= '0;
            c_out_r <= co;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
      // Flags follow the state being entered so they line up with it
      busy_r <= (state_s == ADD);
      done_r <= (state_s == DONE);
    end
  end

  // Drive the external adder only in ADD; quiet zeros elsewhere
  always_comb begin
    x       = 4'd0;
    y       = 4'd0;
    ci      = 1'b0;
    b_nib_s = b_r[{idx_r, 2'b00} +: 4];
    if (state_r == ADD) begin
      x  = a_r[{idx_r, 2'b00} +: 4];
      y  = sub_r ? ~b_nib_s : b_nib_s;
      ci = carry_r;
    end else begin
      x  = 4'd0;
      y  = 4'd0;
      ci = 1'b0;
    end
  end

  assign sum   = sum_r;
  assign c_out = c_out_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES = 4).
// The external 4-bit adder is modelled as {co, s} = x + y + ci. The expected
// result of each accepted operation is pushed to a queue and is popped when
// done pulses.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        c_in = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic        sub = 1'b0;
`endif
  logic [3:0]  x;
  logic [3:0]  y;
  logic        ci;
  logic [3:0]  s;
  logic        co;
  logic [15:0] sum;
  logic        c_out;
  logic        busy;
  logic        done;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [16:0] sb[$];
  logic [16:0] exp_v;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub   (sub),
`endif
    .x     (x),
    .y     (y),
    .ci    (ci),
    .s     (s),
    .co    (co),
    .sum   (sum),
    .c_out (c_out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // External 4-bit adder
  assign {co, s} = {1'b0, x} + {1'b0, y} + {4'd0, ci};

  // Present one operation; the start edge is consumed and the expected result queued.
  // Returns 1 ns after the accepting edge.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input logic tsub);
    @(negedge clk);
    a = ta;
    b = tb;
    c_in = tc;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = tsub;
`endif
    start = 1'b1;
    @(posedge clk);
    if (tsub) sb.push_back({1'b0, ta} + {1'b0, ~tb} + 17'd1);
    else      sb.push_back({1'b0, ta} + {1'b0, tb} + {16'd0, tc});
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
    chk_cnt++;
    if (x !== 4'd0 || y !== 4'd0 || ci !== 1'b0) $display("FAIL reset_xyci x=%h y=%h ci=%b want 0", x, y, ci);
    else pass_cnt++;
    chk_cnt++;
    if (sum !== 16'd0 || c_out !== 1'b0) $display("FAIL reset_result sum=%h c_out=%b want 0", sum, c_out);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] ex[4];
    logic [3:0] ey[4];
    ex = '{4'h4, 4'h3, 4'h2, 4'h1};
    ey = '{4'h1, 4'h2, 4'h3, 4'h4};
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      chk_cnt++;
      if (busy !== 1'b1 || done !== 1'b0 || x !== ex[n] || y !== ey[n])
        $display("FAIL basic_nibble%0d busy=%b done=%b x=%h y=%h want 1 0 %h %h", n, busy, done, x, y, ex[n], ey[n]);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    chk_cnt++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_done done=%b busy=%b want 1 0", done, busy);
    else pass_cnt++;
    exp_v = (sb.size() > 0) ? sb.pop_front() : 17'h1ffff;
    chk_cnt++;
    if ({c_out, sum} !== exp_v || sum !== 16'h5555 || c_out !== 1'b0)
      $display("FAIL basic_result got=%h want=%h", {c_out, sum}, exp_v);
    else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (done !== 1'b0 || sum !== 16'h5555) $display("FAIL basic_idle done=%b sum=%h want 0 5555", done, sum);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      chk_cnt++;
      if (busy !== 1'b1 || ci !== 1'b1) $display("FAIL carry_ci%0d busy=%b ci=%b want 1 1", n, busy, ci);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    exp_v = (sb.size() > 0) ? sb.pop_front() : 17'h0ffff;
    chk_cnt++;
    if (done !== 1'b1 || {c_out, sum} !== exp_v || exp_v !== 17'h10000)
      $display("FAIL carry_result done=%b got=%h want=%h", done, {c_out, sum}, exp_v);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_hold();
    for (int k = 0; k < 6; k++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'b0);
      repeat (4) @(posedge clk);
      #1;
      exp_v = (sb.size() > 0) ? sb.pop_front() : 17'h1ffff;
      chk_cnt++;
      if (done !== 1'b1 || {c_out, sum} !== exp_v)
        $display("FAIL random%0d done=%b got=%h want=%h", k, done, {c_out, sum}, exp_v);
      else pass_cnt++;
      // Result must hold through IDLE while inputs wander with start low
      for (int h = 0; h < 3; h++) begin
        @(negedge clk);
        a = 16'($urandom);
        b = 16'($urandom);
        @(posedge clk);
        #1;
      end
      chk_cnt++;
      if ({c_out, sum} !== exp_v || busy !== 1'b0 || x !== 4'd0 || y !== 4'd0)
        $display("FAIL hold%0d got=%h want=%h busy=%b x=%h y=%h", k, {c_out, sum}, exp_v, busy, x, y);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1;
    a = 16'($urandom);
    b = 16'($urandom);
    c_in = 1'($urandom_range(1, 0));
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(posedge clk);
      if (cyc % 6 == 0) sb.push_back({1'b0, a} + {1'b0, b} + {16'd0, c_in});
      #1;
      chk_cnt++;
      if (done !== ((cyc % 6 == 4) ? 1'b1 : 1'b0) || busy !== ((cyc % 6 < 4) ? 1'b1 : 1'b0) || (busy & done))
        $display("FAIL b2b_flags cyc=%0d busy=%b done=%b", cyc, busy, done);
      else pass_cnt++;
      if (done === 1'b1) begin
        exp_v = (sb.size() > 0) ? sb.pop_front() : 17'h1ffff;
        chk_cnt++;
        if ({c_out, sum} !== exp_v) $display("FAIL b2b_result cyc=%0d got=%h want=%h", cyc, {c_out, sum}, exp_v);
        else pass_cnt++;
      end
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      c_in = 1'($urandom_range(1, 0));
    end
    start = 1'b0;
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL b2b_pending left=%0d want 0", sb.size());
    else pass_cnt++;
    sb.delete();
  endtask

  task automatic test_reset_abort();
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || x !== 4'd0 || y !== 4'd0 || ci !== 1'b0 || sum !== 16'd0 || c_out !== 1'b0)
      $display("FAIL abort_zero busy=%b done=%b x=%h y=%h ci=%b sum=%h c_out=%b want all 0",
               busy, done, x, y, ci, sum, c_out);
    else pass_cnt++;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      chk_cnt++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_quiet%0d done=%b busy=%b want 0 0", n, done, busy);
      else pass_cnt++;
    end
    issue(16'hA5C3, 16'h5A7E, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    exp_v = (sb.size() > 0) ? sb.pop_front() : 17'h1ffff;
    chk_cnt++;
    if (done !== 1'b1 || {c_out, sum} !== exp_v)
      $display("FAIL abort_restart done=%b got=%h want=%h", done, {c_out, sum}, exp_v);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

`ifdef NIBBLE_SERIAL_SUB_EN
  task automatic test_sub();
    logic [15:0] sa[2];
    logic [15:0] sbv[2];
    logic [16:0] want[2];
    sa = '{16'h0005, 16'h0007};
    sbv = '{16'h0007, 16'h0005};
    want = '{17'h0FFFE, 17'h10002};
    for (int k = 0; k < 2; k++) begin
      issue(sa[k], sbv[k], 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      exp_v = (sb.size() > 0) ? sb.pop_front() : 17'h1ffff;
      chk_cnt++;
      if (done !== 1'b1 || {c_out, sum} !== exp_v || {c_out, sum} !== want[k])
        $display("FAIL sub%0d done=%b got=%h want=%h", k, done, {c_out, sum}, want[k]);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_random_hold();
    test_back_to_back();
    test_reset_abort();
`ifdef NIBBLE_SERIAL_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
